// File: rtl/crtc_timing.sv
// Character-based CRT timing generator: sync, display enable and video address per character strobe.
// Outputs update one clk after each strobe; frame_o pulses for one clk at frame start.
module crtc_timing (
  input  logic       clk_16_i,
  input  logic       reset_i,
  input  logic       char_strobe_i,
  input  logic       reg_we_i,
  input  logic [2:0] reg_addr_i,
  input  logic [7:0] reg_data_i,
  output logic       h_sync_o,
  output logic       v_sync_o,
  output logic       de_o,
  output logic [9:0] ma_o,
  output logic [2:0] ra_o,
  output logic       frame_o
);

  typedef enum logic {ROWS = 1'b0, ADJUST = 1'b1} vstate_e;

  logic [7:0] h_total_q, h_disp_q, h_sync_pos_q;
  logic [3:0] h_sync_wid_q;
  logic [7:0] v_total_q, v_disp_q, v_sync_pos_q;
  logic [3:0] v_adjust_q;

  vstate_e    state_q, state_d;
  logic [7:0] h_cnt_q, h_cnt_d;
  logic [2:0] ra_q, ra_d;
  logic [7:0] row_q, row_d;
  logic [3:0] adj_cnt_q, adj_cnt_d;
  logic [9:0] row_start_q, row_start_d;
  logic [7:0] vtot_sh_q, vtot_sh_d;
  logic [3:0] vadj_sh_q, vadj_sh_d;
  logic       frame_start;

  logic       h_sync_q, h_sync_d;
  logic       v_sync_q, v_sync_d;
  logic       de_q, de_d;
  logic [9:0] ma_q, ma_d;
  logic       frame_q, frame_d;

  always_ff @(posedge clk_16_i or posedge reset_i) begin
    if (reset_i) begin
      h_total_q    <= 8'd63;
      h_disp_q     <= 8'd40;
      h_sync_pos_q <= 8'd48;
      h_sync_wid_q <= 4'd4;
      v_total_q    <= 8'd31;
      v_disp_q     <= 8'd25;
      v_sync_pos_q <= 8'd28;
      v_adjust_q   <= 4'd4;
    end else if (reg_we_i) begin
      case (reg_addr_i)
        3'd0: h_total_q    <= reg_data_i;
        3'd1: h_disp_q     <= reg_data_i;
        3'd2: h_sync_pos_q <= reg_data_i;
        3'd3: h_sync_wid_q <= reg_data_i[3:0];
        3'd4: v_total_q    <= reg_data_i;
        3'd5: v_disp_q     <= reg_data_i;
        3'd6: v_sync_pos_q <= reg_data_i;
        default: v_adjust_q <= reg_data_i[3:0];
      endcase
    end
  end

  always_ff @(posedge clk_16_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ROWS;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter stepping; the comparisons use register values from before any coincident write.
  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    ra_d        = ra_q;
    row_d       = row_q;
    adj_cnt_d   = adj_cnt_q;
    row_start_d = row_start_q;
    vtot_sh_d   = vtot_sh_q;
    vadj_sh_d   = vadj_sh_q;
    frame_start = 1'b0;
    if (char_strobe_i) begin
      if (h_cnt_q >= h_total_q) begin
        h_cnt_d = 8'd0;
        case (state_q)
          ROWS: begin
            if (ra_q == 3'd7) begin
              row_start_d = row_start_q + {2'b00, h_disp_q};
              if (row_q >= vtot_sh_q) begin
                if (vadj_sh_q != 4'd0) begin
                  state_d   = ADJUST;
                  ra_d      = 3'd0;
                  adj_cnt_d = 4'd0;
                end else begin
                  frame_start = 1'b1;
                end
              end else begin
                row_d = row_q + 8'd1;
                ra_d  = 3'd0;
              end
            end else begin
              ra_d = ra_q + 3'd1;
            end
          end
          default: begin
            if (adj_cnt_q == (vadj_sh_q - 4'd1)) begin
              frame_start = 1'b1;
            end else begin
              adj_cnt_d = adj_cnt_q + 4'd1;
            end
          end
        endcase
        if (frame_start) begin
          state_d     = ROWS;
          row_d       = 8'd0;
          ra_d        = 3'd0;
          adj_cnt_d   = 4'd0;
          row_start_d = 10'd0;
          vtot_sh_d   = v_total_q;
          vadj_sh_d   = v_adjust_q;
        end
      end else begin
        h_cnt_d = h_cnt_q + 8'd1;
      end
    end
  end

  // Outputs are derived from the post-step counters so they line up with the new position.
  always_comb begin
    h_sync_d = ({1'b0, h_cnt_d} >= {1'b0, h_sync_pos_q}) &&
               ({1'b0, h_cnt_d} < ({1'b0, h_sync_pos_q} + {5'b00000, h_sync_wid_q}));
    v_sync_d = (state_d == ROWS) && (row_d == v_sync_pos_q) && (v_sync_pos_q <= vtot_sh_d);
    de_d     = (h_cnt_d < h_disp_q) && (row_d < v_disp_q) && (state_d == ROWS);
    ma_d     = (h_cnt_d < h_disp_q) ? (row_start_d + {2'b00, h_cnt_d}) : ma_q;
    frame_d  = frame_start;
  end

  always_ff @(posedge clk_16_i or posedge reset_i) begin
    if (reset_i) begin
      h_cnt_q     <= 8'd0;
      ra_q        <= 3'd0;
      row_q       <= 8'd0;
      adj_cnt_q   <= 4'd0;
      row_start_q <= 10'd0;
      vtot_sh_q   <= 8'd31;
      vadj_sh_q   <= 4'd4;
      h_sync_q    <= 1'b0;
      v_sync_q    <= 1'b0;
      de_q        <= 1'b1;
      ma_q        <= 10'd0;
      frame_q     <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      ra_q        <= ra_d;
      row_q       <= row_d;
      adj_cnt_q   <= adj_cnt_d;
      row_start_q <= row_start_d;
      vtot_sh_q   <= vtot_sh_d;
      vadj_sh_q   <= vadj_sh_d;
      frame_q     <= frame_d;
      if (char_strobe_i) begin
        h_sync_q <= h_sync_d;
        v_sync_q <= v_sync_d;
        de_q     <= de_d;
        ma_q     <= ma_d;
      end
    end
  end

  assign h_sync_o = h_sync_q;
  assign v_sync_o = v_sync_q;
  assign de_o     = de_q;
  assign ma_o     = ma_q;
  assign ra_o     = ra_q;
  assign frame_o  = frame_q;

endmodule

// File: tb/tb_crtc_timing.sv
// Directed bench for crtc_timing: default raster, register effects, frame spacing and async reset.
module tb_crtc_timing;

  logic       clk = 1'b0;
  logic       rst;
  logic       stb;
  logic       we;
  logic [2:0] addr;
  logic [7:0] dat;
  logic       h_sync, v_sync, de, frame;
  logic [9:0] ma;
  logic [2:0] ra;

  int n_cmp = 0;
  int n_bad = 0;
  int ns = 0;

  crtc_timing dut (
    .clk_16_i      (clk),
    .reset_i       (rst),
    .char_strobe_i (stb),
    .reg_we_i      (we),
    .reg_addr_i    (addr),
    .reg_data_i    (dat),
    .h_sync_o      (h_sync),
    .v_sync_o      (v_sync),
    .de_o          (de),
    .ma_o          (ma),
    .ra_o          (ra),
    .frame_o       (frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_stb(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      stb = 1'b1;
      @(posedge clk);
      #1;
      stb = 1'b0;
      ns++;
    end
  endtask

  task automatic run_to(input int target);
    do_stb(target - ns);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      stb = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic s);
    @(negedge clk);
    we = 1'b1; addr = a; dat = d; stb = s;
    @(posedge clk);
    #1;
    we = 1'b0; stb = 1'b0;
    if (s) ns++;
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      do_stb(1);
      n++;
    end while (!frame && n < 20000);
    chk("frame_seen", frame, 1);
  endtask

  initial begin
    int n;
    int hs_cnt;
    int h;
    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 3'd0; dat = 8'd0;
    idle(3);
    chk("rst_hs", h_sync, 0);
    chk("rst_vs", v_sync, 0);
    chk("rst_de", de, 1);
    chk("rst_ma", ma, 0);
    chk("rst_ra", ra, 0);
    chk("rst_fr", frame, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // line 0 of the default raster, one strobe at a time
    for (int k = 1; k <= 64; k++) begin
      do_stb(1);
      h = k % 64;
      chk("l0_de", de, (h < 40) ? 1 : 0);
      chk("l0_ma", ma, (h < 40) ? h : 39);
      chk("l0_hs", h_sync, (h >= 48 && h < 52) ? 1 : 0);
      chk("l0_fr", frame, 0);
    end
    chk("l1_ra", ra, 1);

    run_to(512);   chk("l8_ma0", ma, 40);  chk("l8_ra", ra, 0);
    run_to(517);   chk("l8_ma5", ma, 45);
    run_to(12736); chk("r24_ma0", ma, 960); chk("r24_ra", ra, 7);
    run_to(12775); chk("r24_ma39", ma, 999); chk("r24_de39", de, 1);
    run_to(12776); chk("r24_de40", de, 0); chk("r24_hold", ma, 999);
    run_to(12800); chk("r25_de", de, 0);   chk("r25_ma", ma, 1000);
    run_to(14335); chk("vs_pre", v_sync, 0);
    run_to(14336); chk("vs_on", v_sync, 1);
    run_to(14847); chk("vs_last", v_sync, 1);
    run_to(14848); chk("vs_off", v_sync, 0);
    run_to(16384); chk("adj_de", de, 0);   chk("adj_ra", ra, 0);
    run_to(16448); chk("adj_ra1", ra, 0);  chk("adj_vs", v_sync, 0);
    run_to(16639); chk("fr_pre", frame, 0);
    run_to(16640); chk("fr_on", frame, 1); chk("fr_ma", ma, 0); chk("fr_ra", ra, 0);
    idle(1);       chk("fr_off", frame, 0);

    // vertical total change waits for the next frame
    wr(3'd4, 8'd19, 1'b0);
    wait_frame(n); chk("frame2_len", n, 16640);
    do_stb(100);
    wr(3'd4, 8'd31, 1'b0);
    wr(3'd7, 8'd0, 1'b0);
    wait_frame(n); chk("frame3_len", n + 100, 10496);
    wait_frame(n); chk("frame4_len", n, 16384);

    // shrinking H_TOTAL below the current count forces a wrap
    do_stb(50);  chk("ht_ma50", ma, 39);
    wr(3'd0, 8'd10, 1'b0);
    do_stb(1);   chk("ht_wrap_ma", ma, 0); chk("ht_wrap_ra", ra, 1);
    do_stb(10);  chk("ht_ma10", ma, 10);   chk("ht_ra10", ra, 1);
    do_stb(1);   chk("ht_ra11", ra, 2);    chk("ht_ma11", ma, 0);
    wr(3'd0, 8'd63, 1'b0);

    // write coincident with strobe uses old H_SYNC_POS for that step
    do_stb(47);  chk("hsp_47", h_sync, 0);
    wr(3'd2, 8'd60, 1'b1); chk("hsp_old", h_sync, 1);
    do_stb(1);   chk("hsp_new", h_sync, 0);
    wr(3'd2, 8'd48, 1'b0);
    wr(3'd3, 8'd0, 1'b0);
    hs_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      do_stb(1);
      if (h_sync) hs_cnt++;
    end
    chk("hsw0_cnt", hs_cnt, 0);

    // no strobe: everything holds
    idle(20);
    chk("frz_ma", ma, 39);
    chk("frz_ra", ra, 3);
    chk("frz_de", de, 0);

    // asynchronous reset between edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ma", ma, 0);
    chk("arst_ra", ra, 0);
    chk("arst_de", de, 1);
    chk("arst_hs", h_sync, 0);
    chk("arst_vs", v_sync, 0);
    @(negedge clk);
    rst = 1'b0;
    do_stb(1);
    chk("post_ma", ma, 1);
    chk("post_ra", ra, 0);
    chk("post_fr", frame, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
